// File: rtl/mux_2x1_ot.sv
// mux_2x1_ot
//
// Purpose:
//   2:1 multiplexer with a combinational output and a registered copy.
//   A single select line picks I1 (s=1) or I0 (s=0) across all WIDTH bits.
//   The registered copy updates on every rising clk. A valid flag marks when
//   the registered copy holds a value sampled since the last reset.
//
// Ports:
//   clk      in   1      rising-edge clock for y_q and y_q_vld
//   rst_n    in   1      asynchronous active-low reset; release must be
//                        synchronised to clk outside this block
//   I0       in   WIDTH  data selected when s=0
//   I1       in   WIDTH  data selected when s=1
//   s        in   1      select line
//   y        out  WIDTH  combinational selection; reset does not affect it
//   y_q      out  WIDTH  y registered with one cycle of latency
//   y_q_vld  out  1      high from the first rising clk after reset release

module mux_2x1_ot #(
    parameter int WIDTH = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] I0,
    input  logic [WIDTH-1:0] I1,
    input  logic             s,
    output logic [WIDTH-1:0] y,
    output logic [WIDTH-1:0] y_q,
    output logic             y_q_vld
);

    // Pure dataflow select, so y has no clock or reset dependency.
    assign y = s ? I1 : I0;

    // Reset clears y_q and the flag together, so a held value is dropped
    // as a whole and never partly updated.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            y_q     <= '0;
            y_q_vld <= 1'b0;
        end else begin
            y_q     <= y;
            y_q_vld <= 1'b1;
        end
    end

endmodule

// File: tb/tb_mux_2x1_ot.sv
module tb_mux_2x1_ot;

    logic       clk;
    logic       rst_n;

    logic       I0_1, I1_1, s_1;
    logic       y_1, y_q_1, y_q_vld_1;

    logic [7:0] I0_8, I1_8;
    logic       s_8;
    logic [7:0] y_8, y_q_8;
    logic       y_q_vld_8;

    int n_cmp;
    int n_bad;

    mux_2x1_ot #(.WIDTH(1)) u_dut1 (
        .clk     (clk),
        .rst_n   (rst_n),
        .I0      (I0_1),
        .I1      (I1_1),
        .s       (s_1),
        .y       (y_1),
        .y_q     (y_q_1),
        .y_q_vld (y_q_vld_1)
    );

    mux_2x1_ot #(.WIDTH(8)) u_dut8 (
        .clk     (clk),
        .rst_n   (rst_n),
        .I0      (I0_8),
        .I1      (I1_8),
        .s       (s_8),
        .y       (y_8),
        .y_q     (y_q_8),
        .y_q_vld (y_q_vld_8)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [7:0] got, input logic [7:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    typedef struct {
        logic i0;
        logic i1;
        logic s;
        logic y;
    } vec1_t;

    vec1_t vecs[6];

    initial begin
        logic [7:0] exp_y;
        logic [7:0] prev_y;

        n_cmp = 0;
        n_bad = 0;

        vecs[0] = '{1'b0, 1'b0, 1'b0, 1'b0};
        vecs[1] = '{1'b0, 1'b1, 1'b0, 1'b0};
        vecs[2] = '{1'b1, 1'b0, 1'b1, 1'b0};
        vecs[3] = '{1'b1, 1'b1, 1'b1, 1'b1};
        vecs[4] = '{1'b1, 1'b1, 1'b0, 1'b1};
        vecs[5] = '{1'b0, 1'b1, 1'b1, 1'b1};

        rst_n = 1'b0;
        I0_1 = 1'b0; I1_1 = 1'b0; s_1 = 1'b0;
        I0_8 = 8'hA5; I1_8 = 8'h3C; s_8 = 1'b0;

        #1;
        check_eq("rst_yq1",   {7'd0, y_q_1},     8'h00);
        check_eq("rst_vld1",  {7'd0, y_q_vld_1}, 8'h00);
        check_eq("rst_yq8",   y_q_8,             8'h00);
        check_eq("rst_vld8",  {7'd0, y_q_vld_8}, 8'h00);
        check_eq("rst_y8",    y_8,               8'hA5);

        // Truth table while still in reset: y must be unaffected.
        foreach (vecs[i]) begin
            I0_1 = vecs[i].i0; I1_1 = vecs[i].i1; s_1 = vecs[i].s;
            #1;
            check_eq($sformatf("tt_y_%0d", i), {7'd0, y_1}, {7'd0, vecs[i].y});
        end

        // Reset holds across a clock edge.
        @(posedge clk); #1;
        check_eq("rst_hold_yq1", {7'd0, y_q_1}, 8'h00);
        check_eq("rst_hold_vld1", {7'd0, y_q_vld_1}, 8'h00);

        // Release and first capture.
        @(negedge clk);
        I0_1 = 1'b0; I1_1 = 1'b1; s_1 = 1'b1;
        rst_n = 1'b1;
        #1;
        check_eq("rel_vld_pre", {7'd0, y_q_vld_1}, 8'h00);
        @(posedge clk); #1;
        check_eq("rel_vld1",  {7'd0, y_q_vld_1}, 8'h01);
        check_eq("rel_yq1",   {7'd0, y_q_1},     8'h01);
        check_eq("rel_vld8",  {7'd0, y_q_vld_8}, 8'h01);
        check_eq("rel_yq8",   y_q_8,             8'hA5);

        // Mid-cycle async reset with I0=1, s=0.
        @(negedge clk);
        I0_1 = 1'b1; I1_1 = 1'b0; s_1 = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        check_eq("ar_y1",    {7'd0, y_1},       8'h01);
        check_eq("ar_yq1",   {7'd0, y_q_1},     8'h00);
        check_eq("ar_vld1",  {7'd0, y_q_vld_1}, 8'h00);
        check_eq("ar_yq8",   y_q_8,             8'h00);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
        check_eq("ar_rel_yq1",  {7'd0, y_q_1},     8'h01);
        check_eq("ar_rel_vld1", {7'd0, y_q_vld_1}, 8'h01);

        // WIDTH=8: toggle s each cycle, y_q trails y by one clock.
        prev_y = 8'hA5;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            s_8 = (i % 2 == 1);
            exp_y = s_8 ? 8'h3C : 8'hA5;
            #1;
            check_eq($sformatf("w8_y_%0d", i),   y_8,   exp_y);
            check_eq($sformatf("w8_qpre_%0d", i), y_q_8, prev_y);
            @(posedge clk); #1;
            check_eq($sformatf("w8_q_%0d", i),   y_q_8, exp_y);
            prev_y = exp_y;
        end

        // I0 == I1 on the wide instance: s is irrelevant.
        @(negedge clk);
        I0_8 = 8'h5A; I1_8 = 8'h5A; s_8 = 1'b0;
        #1 check_eq("eq_s0", y_8, 8'h5A);
        s_8 = 1'b1;
        #1 check_eq("eq_s1", y_8, 8'h5A);

        // Mixed bits: select must act on every bit from the one s.
        I0_8 = 8'hF0; I1_8 = 8'h0F; s_8 = 1'b0;
        #1 check_eq("bw_s0", y_8, 8'hF0);
        s_8 = 1'b1;
        #1 check_eq("bw_s1", y_8, 8'h0F);

        // Mid-operation reset discards the held wide value.
        @(posedge clk); #1;
        check_eq("pre_rst_yq8", y_q_8, 8'h0F);
        #2 rst_n = 1'b0;
        #1;
        check_eq("mid_rst_yq8",  y_q_8,             8'h00);
        check_eq("mid_rst_vld8", {7'd0, y_q_vld_8}, 8'h00);
        check_eq("mid_rst_y8",   y_8,               8'h0F);

        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
        check_eq("final_yq8", y_q_8, 8'h0F);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/mux_2x1_ot.md
MUX_2X1_OT -- requirements
Module: mux_2x1_ot

Interface
REQ-001 Parameter WIDTH, default 1, data width of I0, I1, y and y_q; the block SHALL support any WIDTH >= 1.
REQ-002 Port clk, input, 1, the single clock; all registers SHALL sample on its rising edge.
REQ-003 Port rst_n, input, 1, asynchronous active-low reset.
REQ-004 Port I0, input, WIDTH, data input selected when s=0.
REQ-005 Port I1, input, WIDTH, data input selected when s=1.
REQ-006 Port s, input, 1, select line.
REQ-007 Port y, output, WIDTH, combinational mux output.
REQ-008 Port y_q, output, WIDTH, registered copy of y.
REQ-009 Port y_q_vld, output, 1, high once y_q holds a sampled value since the last reset.

Function
REQ-010 y SHALL equal I1 when s=1, and I0 when s=0.
- Implement as a pure dataflow expression.
- Zero clock latency; y follows input changes within the same delta/time step, with no clock or reset dependency.
REQ-011 The selection in REQ-010 SHALL apply bitwise across all WIDTH bits using the single s.
REQ-012 Each rising clk with rst_n high SHALL load y_q with the current value of y (one-cycle latency).
REQ-013 y_q_vld SHALL go high on the first rising clk after reset release and remain high until the next reset.
REQ-014 Inputs changing exactly at a clock edge: y_q SHALL capture the pre-edge value of y.
REQ-015 I0 equal to I1: y SHALL equal that common value regardless of s.
- No glitch requirement beyond normal synthesis.

Reset
REQ-016 rst_n low SHALL immediately (asynchronously) force y_q to all-zeros and y_q_vld to 0.
REQ-017 Reset SHALL NOT affect y; y remains the combinational selection during and after reset.
REQ-018 Release of rst_n SHALL be synchronised externally.
- The block SHALL resume registering on the first rising clk with rst_n high.
REQ-019 Reset asserted mid-operation SHALL discard the held y_q value with no partial update.

Structure
REQ-020 No shared package is needed.
- WIDTH is the only configuration constant.
- No typedefs are required.
REQ-021 The block SHALL be a single module with no sub-modules.
- The combinational mux and the output register reside in the same module.

Verification
REQ-022 I0=0, I1=0, s=0 -> y=0.
REQ-023 I0=0, I1=1, s=0 -> y=0 (selects I0).
REQ-024 I0=1, I1=0, s=1 -> y=0 (selects I1).
REQ-025 I0=1, I1=1, s=1 -> y=1.
REQ-026 rst_n=0 with I0=1, s=0 -> y=1 immediately, y_q=0, y_q_vld=0.
- Release rst_n, then one rising clk -> y_q=1, y_q_vld=1.
REQ-027 WIDTH=8, I0=8'hA5, I1=8'h3C, toggling s each cycle:
- y alternates A5/3C.
- y_q shows the same sequence delayed by one clock.
